// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: word width, control tokens, decoder FSM states
// and the 10b->8b data decode used by the receive channel.
package tmds_pkg;

  localparam int unsigned TMDS_WORDW = 10;

  localparam logic [TMDS_WORDW-1:0] CTRL_00 = 10'h354;
  localparam logic [TMDS_WORDW-1:0] CTRL_01 = 10'h0AB;
  localparam logic [TMDS_WORDW-1:0] CTRL_10 = 10'h154;
  localparam logic [TMDS_WORDW-1:0] CTRL_11 = 10'h2AB;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } tmds_state_e;

  // bit 9 undoes the DC-balance inversion, bit 8 selects XOR vs XNOR chaining
  function automatic logic [7:0] tmds_decode(input logic [TMDS_WORDW-1:0] w);
    logic [7:0] d;
    logic [7:0] o;
    d    = w[9] ? ~w[7:0] : w[7:0];
    o    = '0;
    o[0] = d[0];
    for (int unsigned i = 1; i < 8; i++) begin
      o[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

endpackage

// File: rtl/tmds_word_align.sv
// Two-word history of the deserialized stream and the 20-to-10 barrel select
// that extracts the word starting at bit offset_i (bit 0 = earliest on wire).
module tmds_word_align
  import tmds_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [TMDS_WORDW-1:0] word_i,
  input  logic [3:0]            offset_i,
  output logic [TMDS_WORDW-1:0] word_o
);

  logic [TMDS_WORDW-1:0]   word_q;
  logic [TMDS_WORDW-1:0]   prev_q;
  logic [2*TMDS_WORDW-1:0] window;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      prev_q <= '0;
    end else begin
      word_q <= word_i;
      prev_q <= word_q;
    end
  end

  assign window = {word_q, prev_q};
  assign word_o = window[offset_i +: TMDS_WORDW];

endmodule

// File: rtl/tmds_decoder.sv
// One TMDS receive channel: self-aligns on control-token runs, then decodes
// pixels/control. Define TMDS_DEC_STATS_EN to count lock-loss events.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned CTRL_RUN       = 16,
  parameter int unsigned SEARCH_TIMEOUT = 2048,
  parameter int unsigned LOSS_TIMEOUT   = 4096
) (
  input  logic                  clk_pix,
  input  logic                  rst_pix_n,
  input  logic [TMDS_WORDW-1:0] tmds_in,
  output logic                  de,
  output logic [1:0]            ctrl,
  output logic [7:0]            data,
  output logic                  locked,
  output logic [3:0]            align_offset,
  output logic [15:0]           lock_loss_cnt
);

  localparam int unsigned RUN_W  = $clog2(CTRL_RUN);
  localparam int unsigned TMO_W  = $clog2(SEARCH_TIMEOUT);
  localparam int unsigned LOSS_W = $clog2(LOSS_TIMEOUT);

  tmds_state_e           state_q;
  logic [3:0]            offset_q;
  logic [RUN_W-1:0]      run_q;
  logic [TMO_W-1:0]      tmo_q;
  logic [LOSS_W-1:0]     loss_q;
  logic [1:0]            flush_q;
  logic                  de_q;
  logic [1:0]            ctrl_q;
  logic [7:0]            data_q;

  logic [TMDS_WORDW-1:0] aligned;
  logic                  tok;
  logic [1:0]            tok_ctrl;
  logic                  drop;

  tmds_word_align u_align (
    .clk_i    (clk_pix),
    .rst_ni   (rst_pix_n),
    .word_i   (tmds_in),
    .offset_i (offset_q),
    .word_o   (aligned)
  );

  always_comb begin
    tok      = 1'b1;
    tok_ctrl = 2'b00;
    case (aligned)
      CTRL_00: tok_ctrl = 2'b00;
      CTRL_01: tok_ctrl = 2'b01;
      CTRL_10: tok_ctrl = 2'b10;
      CTRL_11: tok_ctrl = 2'b11;
      default: tok      = 1'b0;
    endcase
  end

  assign drop = (state_q == LOCKED) && !tok && (loss_q == LOSS_W'(LOSS_TIMEOUT - 1));

  // Counters are bounded by their thresholds, so they never wrap. Outputs
  // follow the next state: they are zero whenever locked reads 0.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q  <= SEARCH;
      offset_q <= '0;
      run_q    <= '0;
      tmo_q    <= '0;
      loss_q   <= '0;
      flush_q  <= '0;
      de_q     <= 1'b0;
      ctrl_q   <= '0;
      data_q   <= '0;
    end else begin
      case (state_q)
        SEARCH: begin
          de_q   <= 1'b0;
          ctrl_q <= '0;
          data_q <= '0;
          if (flush_q != 2'd0) begin
            flush_q <= flush_q - 2'd1;
          end else if (tok) begin
            tmo_q <= '0;
            if (run_q == RUN_W'(CTRL_RUN - 1)) begin
              state_q <= LOCKED;
              run_q   <= '0;
              loss_q  <= '0;
              ctrl_q  <= tok_ctrl;
            end else begin
              run_q <= run_q + RUN_W'(1);
            end
          end else begin
            run_q <= '0;
            if (tmo_q == TMO_W'(SEARCH_TIMEOUT - 1)) begin
              tmo_q    <= '0;
              offset_q <= (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
              flush_q  <= 2'd2;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
        end
        LOCKED: begin
          if (tok) begin
            loss_q <= '0;
            de_q   <= 1'b0;
            ctrl_q <= tok_ctrl;
            data_q <= '0;
          end else if (drop) begin
            state_q <= SEARCH;
            loss_q  <= '0;
            run_q   <= '0;
            tmo_q   <= '0;
            de_q    <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
          end else begin
            loss_q <= loss_q + LOSS_W'(1);
            de_q   <= 1'b1;
            data_q <= tmds_decode(aligned);
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

`ifdef TMDS_DEC_STATS_EN
  logic [15:0] loss_evt_q;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      loss_evt_q <= '0;
    end else if (drop && (loss_evt_q != '1)) begin
      loss_evt_q <= loss_evt_q + 16'd1;
    end
  end

  assign lock_loss_cnt = loss_evt_q;
`else
  assign lock_loss_cnt = '0;
`endif

  assign de           = de_q;
  assign ctrl         = ctrl_q;
  assign data         = data_q;
  assign locked       = (state_q == LOCKED);
  assign align_offset = offset_q;

endmodule
